red_xor_stream_check: RTL and testbench

- Streaming packet parity checker that sits directly downstream of the reduction-XOR stage.
- Consumes a valid/ready word stream delimited by a last flag and XOR-reduces every bit of every beat into a running parity.
- On the last beat, compares the running parity with a received parity bit and emits one result token per packet through a valid/ready handshake.
- Sits between a word source (bus/FIFO) and an error/status collector.

---
 rtl/red_xor_stream_check_if.sv | 28 ++
 rtl/red_xor_stream_check.sv | 85 ++++++++
 tb/tb_red_xor_stream_check.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/red_xor_stream_check_if.sv
// Word stream in and per-packet parity result out of red_xor_stream_check.
// Valid/ready rule on both channels: a transfer happens on a rising edge where valid && ready;
// a valid, once raised, is held with its payload until that transfer.
interface red_xor_stream_check_if #(
  parameter int width    = 8,
  parameter int cntWidth = 16
);
  logic [width-1:0]    A;
  logic                A_valid;
  logic                A_last;
  logic                P;
  logic                A_ready;
  logic                Z;
  logic                Err;
  logic [cntWidth-1:0] Cnt;
  logic                Z_valid;
  logic                Z_ready;

  modport slave (
    input  A, A_valid, A_last, P, Z_ready,
    output A_ready, Z, Err, Cnt, Z_valid
  );

  modport master (
    output A, A_valid, A_last, P, Z_ready,
    input  A_ready, Z, Err, Cnt, Z_valid
  );
endinterface

// File: rtl/red_xor_stream_check.sv
// Packet parity checker: XOR-reduces every beat of a packet, compares with the received
// parity bit on the last beat and emits one {Z, Err, Cnt} token per packet.
module red_xor_stream_check #(
  parameter int width    = 8,
  parameter bit odd      = 1'b0,
  parameter int cntWidth = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  red_xor_stream_check_if.slave s,
  output logic state_o
);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t              state_q;
  logic                acc_q;
  logic [cntWidth-1:0] cnt_q;
  logic                z_q;
  logic                err_q;
  logic [cntWidth-1:0] rcnt_q;

  logic [width-1:0]    a_w;
  logic                wp;
  logic                a_ready;
  logic                accept;
  logic                acc_d;
  logic [cntWidth-1:0] cnt_d;
  logic                par_d;

  assign a_w     = s.A;
  assign wp      = ^a_w;
  // In DONE the input is opened only when the pending token leaves on this same edge.
  assign a_ready = (state_q == ACCUM) ? 1'b1 : s.Z_ready;
  assign accept  = s.A_valid && a_ready;

  always_comb begin
    acc_d = acc_q ^ wp;
    cnt_d = (cnt_q == {cntWidth{1'b1}}) ? cnt_q : cnt_q + cntWidth'(1);
    par_d = acc_d ^ odd;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ACCUM;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
      z_q     <= 1'b0;
      err_q   <= 1'b0;
      rcnt_q  <= '0;
    end else begin
      if (state_q == DONE && s.Z_ready) begin
        state_q <= ACCUM;
      end
      // acc/cnt are already cleared while DONE, so a pass-through beat starts a fresh packet.
      if (accept) begin
        if (s.A_last) begin
          z_q     <= par_d;
          err_q   <= par_d != s.P;
          rcnt_q  <= cnt_d;
          acc_q   <= 1'b0;
          cnt_q   <= '0;
          state_q <= DONE;
        end else begin
          acc_q <= acc_d;
          cnt_q <= cnt_d;
        end
      end
    end
  end

  assign s.A_ready = a_ready;
  assign s.Z_valid = (state_q == DONE);
  assign s.Z       = z_q;
  assign s.Err     = err_q;
  assign s.Cnt     = rcnt_q;
  assign state_o   = state_q;

  a_valid_held: assert property (@(posedge clk_i) disable iff (rst_i)
    (s.A_valid && !a_ready) |=> s.A_valid);

endmodule

// File: tb/tb_red_xor_stream_check.sv
// Bench for red_xor_stream_check: three instances (even/16-bit count, odd/16-bit count,
// even/2-bit count) share one stimulus stream and are checked against a packet-level model.
module tb_red_xor_stream_check;

  localparam int TW = 18;  // token = {Z, Err, Cnt[15:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] a = 8'h00;
  logic a_valid = 1'b0;
  logic a_last  = 1'b0;
  logic p       = 1'b0;
  logic z_ready = 1'b1;

  red_xor_stream_check_if #(.width(8), .cntWidth(16)) if0 ();
  red_xor_stream_check_if #(.width(8), .cntWidth(16)) if1 ();
  red_xor_stream_check_if #(.width(8), .cntWidth(2))  if2 ();

  assign if0.A = a;  assign if0.A_valid = a_valid;  assign if0.A_last = a_last;
  assign if0.P = p;  assign if0.Z_ready = z_ready;
  assign if1.A = a;  assign if1.A_valid = a_valid;  assign if1.A_last = a_last;
  assign if1.P = p;  assign if1.Z_ready = z_ready;
  assign if2.A = a;  assign if2.A_valid = a_valid;  assign if2.A_last = a_last;
  assign if2.P = p;  assign if2.Z_ready = z_ready;

  logic st0, st1, st2;

  red_xor_stream_check #(.width(8), .odd(1'b0), .cntWidth(16)) u0 (
    .clk_i(clk), .rst_i(rst), .s(if0.slave), .state_o(st0));
  red_xor_stream_check #(.width(8), .odd(1'b1), .cntWidth(16)) u1 (
    .clk_i(clk), .rst_i(rst), .s(if1.slave), .state_o(st1));
  red_xor_stream_check #(.width(8), .odd(1'b0), .cntWidth(2)) u2 (
    .clk_i(clk), .rst_i(rst), .s(if2.slave), .state_o(st2));

  logic        z_o [3];
  logic        err_o[3];
  logic        zv_o [3];
  logic        ar_o [3];
  logic [15:0] cnt_o[3];

  assign z_o[0] = if0.Z;  assign err_o[0] = if0.Err;  assign zv_o[0] = if0.Z_valid;
  assign ar_o[0] = if0.A_ready;  assign cnt_o[0] = if0.Cnt;
  assign z_o[1] = if1.Z;  assign err_o[1] = if1.Err;  assign zv_o[1] = if1.Z_valid;
  assign ar_o[1] = if1.A_ready;  assign cnt_o[1] = if1.Cnt;
  assign z_o[2] = if2.Z;  assign err_o[2] = if2.Err;  assign zv_o[2] = if2.Z_valid;
  assign ar_o[2] = if2.A_ready;  assign cnt_o[2] = {14'd0, if2.Cnt};

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected token of one packet for a given parity sense and counter width.
  function automatic logic [TW-1:0] mk_tok(input int n, input int ones, input bit o,
                                           input int cw, input bit pp);
    logic z;
    int   mx;
    int   c;
    z  = ((ones % 2) == 1) ^ o;
    mx = (1 << cw) - 1;
    c  = (n > mx) ? mx : n;
    return {z, z != pp, 16'(c)};
  endfunction

  logic [3*TW-1:0] exp_q[$];   // one entry per packet: tokens of u0, u1, u2
  logic [7:0]      pkt_q[$];   // words of the packet being received

  always @(negedge clk) begin
    logic [3*TW-1:0] tok;
    logic [TW-1:0]   t;
    bit              pend;
    int              ones;
    if (rst) begin
      exp_q.delete();
      pkt_q.delete();
    end else begin
      pend = exp_q.size() != 0;
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("u%0d A_ready", i), 32'(ar_o[i]), 32'(!pend || z_ready));
        chk($sformatf("u%0d Z_valid", i), 32'(zv_o[i]), 32'(pend));
      end
      if (pend && z_ready) begin
        tok = exp_q.pop_front();
        for (int i = 0; i < 3; i++) begin
          t = tok[(2-i)*TW +: TW];
          chk($sformatf("u%0d token", i), 32'({z_o[i], err_o[i], cnt_o[i]}), 32'(t));
        end
      end
      if (a_valid && (!pend || z_ready)) begin
        pkt_q.push_back(a);
        if (a_last) begin
          ones = 0;
          foreach (pkt_q[k]) ones += $countones(pkt_q[k]);
          exp_q.push_back({mk_tok(pkt_q.size(), ones, 1'b0, 16, p),
                           mk_tok(pkt_q.size(), ones, 1'b1, 16, p),
                           mk_tok(pkt_q.size(), ones, 1'b0, 2,  p)});
          pkt_q.delete();
        end
      end
    end
  end

  // ---------------- driver tasks (entered and left at posedge + 1) ----------------
  task automatic send(input logic [7:0] d, input logic last, input logic pp);
    int budget;
    a = d; a_last = last; p = pp; a_valid = 1'b1;
    budget = 0;
    forever begin
      @(negedge clk);
      if (ar_o[0]) break;
      budget++;
      if (budget > 200) begin
        chk("accept timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
  endtask

  task automatic chk_res(input int i, input string nm, input logic zz, input logic ee,
                         input logic [15:0] cc);
    chk({nm, $sformatf(" u%0d Z_valid", i)}, 32'(zv_o[i]), 32'd1);
    chk({nm, $sformatf(" u%0d Z", i)},       32'(z_o[i]),  32'(zz));
    chk({nm, $sformatf(" u%0d Err", i)},     32'(err_o[i]), 32'(ee));
    chk({nm, $sformatf(" u%0d Cnt", i)},     32'(cnt_o[i]), 32'(cc));
  endtask

  // Single-beat packets: expected Z/Err worked out by hand for even (u0) and odd (u1).
  typedef struct {
    logic [7:0] a;
    logic       p;
    logic       z0, e0, z1, e1;
  } vec_t;

  vec_t vecs[6];

  // ---------------- test sequence ----------------
  initial begin
    int   left;
    bit   took;
    int   budget;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset u%0d Z", i),       32'(z_o[i]),   32'd0);
      chk($sformatf("reset u%0d Err", i),     32'(err_o[i]), 32'd0);
      chk($sformatf("reset u%0d Cnt", i),     32'(cnt_o[i]), 32'd0);
      chk($sformatf("reset u%0d Z_valid", i), 32'(zv_o[i]),  32'd0);
      chk($sformatf("reset u%0d A_ready", i), 32'(ar_o[i]),  32'd1);
    end
    @(posedge clk); #1;

    // table of single-beat packets
    for (int v = 0; v < 6; v++) begin
      send(vecs[v].a, 1'b1, vecs[v].p);
      @(negedge clk);
      chk_res(0, $sformatf("vec%0d", v), vecs[v].z0, vecs[v].e0, 16'd1);
      chk_res(1, $sformatf("vec%0d", v), vecs[v].z1, vecs[v].e1, 16'd1);
      @(posedge clk); #1;
    end

    // three-beat packet held by downstream back-pressure
    z_ready = 1'b0;
    send(8'h01, 1'b0, 1'b0);
    send(8'h03, 1'b0, 1'b0);
    send(8'h07, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_res(0, "hold", 1'b0, 1'b0, 16'd3);
      chk_res(1, "hold", 1'b1, 1'b1, 16'd3);
      chk("hold A_ready", 32'(ar_o[0]), 32'd0);
    end
    @(posedge clk); #1;
    z_ready = 1'b1;
    @(negedge clk);
    chk("release A_ready", 32'(ar_o[0]), 32'd1);
    @(posedge clk); #1;

    // back-to-back single-beat packets, no bubble
    a = 8'hFF; a_last = 1'b1; p = 1'b0; a_valid = 1'b1;
    @(negedge clk);
    chk("b2b A_ready 0", 32'(ar_o[0]), 32'd1);
    @(posedge clk); #1;
    a = 8'h80; p = 1'b1;
    @(negedge clk);
    chk("b2b A_ready 1", 32'(ar_o[0]), 32'd1);
    chk_res(0, "b2b 1", 1'b0, 1'b0, 16'd1);
    @(posedge clk); #1;
    a = 8'h00; p = 1'b0;
    @(negedge clk);
    chk("b2b A_ready 2", 32'(ar_o[0]), 32'd1);
    chk_res(0, "b2b 2", 1'b1, 1'b0, 16'd1);
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(negedge clk);
    chk_res(0, "b2b 3", 1'b0, 1'b0, 16'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b drained", 32'(zv_o[0]), 32'd0);
    @(posedge clk); #1;

    // two-beat packet, odd sense on u1
    send(8'h0F, 1'b0, 1'b0);
    send(8'hF0, 1'b1, 1'b1);
    @(negedge clk);
    chk_res(1, "odd", 1'b1, 1'b0, 16'd2);
    chk_res(0, "odd", 1'b0, 1'b1, 16'd2);
    @(posedge clk); #1;

    // counter saturation on the 2-bit instance
    repeat (5) send(8'h01, 1'b0, 1'b0);
    send(8'h01, 1'b1, 1'b0);
    @(negedge clk);
    chk_res(2, "sat", 1'b0, 1'b0, 16'd3);
    chk_res(0, "sat", 1'b0, 1'b0, 16'd6);
    @(posedge clk); #1;

    // reset in the middle of a packet discards it
    send(8'h13, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid reset Z_valid", 32'(zv_o[0]), 32'd0);
    chk("mid reset A_ready", 32'(ar_o[0]), 32'd1);
    @(posedge clk); #1;
    send(8'h01, 1'b1, 1'b1);
    @(negedge clk);
    chk_res(0, "after reset", 1'b1, 1'b0, 16'd1);
    @(posedge clk); #1;

    // random packets, gaps and back-pressure against the model
    left = $urandom_range(1, 6);
    for (int c = 0; c < 3000; c++) begin
      z_ready = ($urandom_range(0, 3) != 0);
      if (!a_valid && ($urandom_range(0, 3) != 0)) begin
        a = 8'($urandom);
        a_last = (left == 1);
        p = 1'($urandom);
        a_valid = 1'b1;
      end
      @(negedge clk);
      took = a_valid && ar_o[0];
      @(posedge clk); #1;
      if (took) begin
        a_valid = 1'b0;
        left--;
        if (left == 0) left = $urandom_range(1, 6);
      end
    end
    z_ready = 1'b1;
    budget = 0;
    while (a_valid && budget < 20) begin
      @(negedge clk);
      took = ar_o[0];
      @(posedge clk); #1;
      if (took) a_valid = 1'b0;
      budget++;
    end
    a_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("drain tokens", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
